mio_bus_ctrl: RTL and testbench
===============================

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-003 The block SHALL have the port addr, input, 32 bits: CPU byte address, held stable while cpu_mio=1.
REQ-004 The block SHALL have the port wdata, input, 32 bits: CPU store data, held stable while cpu_mio=1.
REQ-005 The block SHALL have the port mem_w, input, 1 bit: 1 = write request, 0 = read request.
REQ-006 The block SHALL have the port cpu_mio, input, 1 bit: CPU bus request strobe.
REQ-007 The block SHALL have the port rdata, output, 32 bits: read data returned to the CPU.
REQ-008 The block SHALL have the port mio_ready, output, 1 bit: transfer-complete pulse.
REQ-009 The block SHALL have the port ram_addr, output, 14 bits: RAM word address.
REQ-010 The block SHALL have the port ram_din, output, 32 bits: RAM write data.
REQ-011 The block SHALL have the port ram_we, output, 1 bit: RAM write enable.
REQ-012 The block SHALL have the port ram_en, output, 1 bit: RAM access enable.
REQ-013 The block SHALL have the port ram_dout, input, 32 bits: synchronous RAM read data, valid one cycle after ram_en.
REQ-014 The block SHALL have the port sw_in, input, 16 bits: asynchronous switch inputs.
REQ-015 The block SHALL have the port led_out, output, 16 bits: LED register.
REQ-016 The block SHALL have the port bus_err, output, 1 bit: unmapped-access pulse.

Function
REQ-017 The address map SHALL be:
- RAM: addr[31:16]=0x0000, ram_addr=addr[15:2].
- LED: 0xF000_0000, read/write.
- SW: 0xF000_0004, read-only.
- CNT: 0xF000_0008, read/write.
- Anything else is unmapped.
REQ-018 The FSM SHALL have the states IDLE, RD_WAIT and RESP.
REQ-019 In IDLE with cpu_mio=1:
- RAM read: ram_en=1 combinationally; next state RD_WAIT.
- All other accesses: perform the access; next state RESP.
REQ-020 A RAM write SHALL drive ram_en=1, ram_we=1 and ram_din=wdata for exactly one cycle, in the IDLE cycle.
REQ-021 RD_WAIT SHALL register ram_dout into rdata and go to RESP.
REQ-022 RESP SHALL:
- drive mio_ready=1 for exactly one cycle, with rdata valid;
- return to IDLE unconditionally.
REQ-023 If cpu_mio is still 1 in the following IDLE cycle, the block SHALL treat it as a new request.
REQ-024 Latency from the request cycle to mio_ready SHALL be 2 cycles for a RAM read and 1 cycle for every other access.
REQ-025 A LED write SHALL load led_out<=wdata[15:0]; a LED read SHALL return {16'b0, led_out}.
REQ-026 sw_in SHALL pass through a 2-flop synchronizer; a SW read SHALL return {16'b0, synchronized value}; a SW write SHALL be ignored but still acknowledged.
REQ-027 CNT SHALL be a 32-bit counter incrementing every cycle and wrapping 0xFFFF_FFFF->0.
REQ-028 A CNT write SHALL load wdata; on a write, the written value SHALL win over the increment.
REQ-029 A CNT read SHALL return the counter value in the request cycle.
REQ-030 An unmapped access SHALL:
- pulse bus_err=1 during the RESP cycle;
- for a read, return rdata=0;
- for a write, change no state;
- still be acknowledged.
REQ-031 When cpu_mio=0 in IDLE, ram_en, ram_we and mio_ready SHALL all be 0.
REQ-032 Requests arriving in RD_WAIT or RESP SHALL be ignored until IDLE.
REQ-033 For unaligned addresses, the block SHALL ignore addr[1:0].

Reset
REQ-034 While reset=0, the block SHALL hold:
- state=IDLE;
- rdata=0, mio_ready=0, ram_we=0, ram_en=0, bus_err=0;
- led_out=0, counter=0, synchronizer=0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer: no mio_ready pulse, and no RAM write after the reset edge.
REQ-036 On reset release, the first request SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-037 Scenario: RAM write addr=0x0000_0010, wdata=0xDEAD_BEEF -> same cycle ram_addr=4, ram_we=1, ram_din=0xDEAD_BEEF; mio_ready=1 one cycle later.
REQ-038 Scenario: RAM read addr=0x0000_0010 with the RAM model returning 0xDEAD_BEEF -> ram_en=1 in the request cycle; rdata=0xDEAD_BEEF and mio_ready=1 two cycles later.
REQ-039 Scenario: write 0x1234_5678 to 0xF000_0000, then read it back -> led_out=0x5678; rdata=0x0000_5678.
REQ-040 Scenario: write 0xFFFF_FFFE to CNT, wait 2 cycles, read -> rdata=0x0000_0000 or 0x0000_0001 per cycle count (wrap checked).
REQ-041 Scenario: read 0x8000_0000 -> rdata=0, bus_err=1 and mio_ready=1 in the same cycle.
REQ-042 Scenario: reset=0 in the RD_WAIT cycle -> no mio_ready pulse; all outputs 0; the next request completes normally.

Source files
------------

// File: rtl/mio_bus_ctrl.sv
// CPU memory/IO bus controller: decodes RAM, LED, switch and free-running counter
// targets, sequences single-beat transfers and returns a one-cycle ready pulse.
module mio_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_w,
  input  logic        cpu_mio,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        ram_we,
  output logic        ram_en,
  input  logic [31:0] ram_dout,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IO_W   = 16;
  localparam int unsigned WA_W   = 30;

  localparam logic [WA_W-1:0] LED_WA = 30'h3C00_0000;
  localparam logic [WA_W-1:0] SW_WA  = 30'h3C00_0001;
  localparam logic [WA_W-1:0] CNT_WA = 30'h3C00_0002;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;
  typedef enum logic [2:0] {SEL_RAM, SEL_LED, SEL_SW, SEL_CNT, SEL_NONE} sel_t;

  state_t            state, state_nxt;
  sel_t              sel;
  logic [DATA_W-1:0] cnt;
  logic [IO_W-1:0]   sw_meta, sw_sync;
  logic              wr_led, wr_cnt, rd_load, err_nxt;
  logic [DATA_W-1:0] rd_val;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];
  assign ram_addr = addr[15:2];
  assign ram_din  = wdata;

  // Word-granular address decode; byte offset bits play no part.
  always_comb begin
    sel = SEL_NONE;
    if (addr[31:16] == 16'h0000)  sel = SEL_RAM;
    else if (addr[31:2] == LED_WA) sel = SEL_LED;
    else if (addr[31:2] == SW_WA)  sel = SEL_SW;
    else if (addr[31:2] == CNT_WA) sel = SEL_CNT;
  end

  // Next state and transfer controls; reset gates the combinational RAM strobes.
  always_comb begin
    state_nxt = state;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    wr_led    = 1'b0;
    wr_cnt    = 1'b0;
    rd_load   = 1'b0;
    rd_val    = '0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_mio && reset) begin
          state_nxt = RESP;
          case (sel)
            SEL_RAM: begin
              ram_en = 1'b1;
              if (mem_w) ram_we = 1'b1;
              else       state_nxt = RD_WAIT;
            end
            SEL_LED: begin
              if (mem_w) wr_led = 1'b1;
              else begin
                rd_load = 1'b1;
                rd_val  = {16'h0000, led_out};
              end
            end
            SEL_SW: begin
              if (!mem_w) begin
                rd_load = 1'b1;
                rd_val  = {16'h0000, sw_sync};
              end
            end
            SEL_CNT: begin
              if (mem_w) wr_cnt = 1'b1;
              else begin
                rd_load = 1'b1;
                rd_val  = cnt;
              end
            end
            default: begin
              err_nxt = 1'b1;
              rd_load = !mem_w;
            end
          endcase
        end
      end
      RD_WAIT: begin
        rd_load   = 1'b1;
        rd_val    = ram_dout;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rdata     <= '0;
      mio_ready <= 1'b0;
      bus_err   <= 1'b0;
      led_out   <= '0;
      cnt       <= '0;
      sw_meta   <= '0;
      sw_sync   <= '0;
    end else begin
      state     <= state_nxt;
      mio_ready <= (state_nxt == RESP);
      bus_err   <= err_nxt;
      sw_meta   <= sw_in;
      sw_sync   <= sw_meta;
      if (rd_load) rdata <= rd_val;
      if (wr_led)  led_out <= wdata[15:0];
      // A CNT store takes priority over the free-running increment.
      cnt <= wr_cnt ? wdata : cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Directed self-checking bench for mio_bus_ctrl with a synchronous RAM model.
module tb_mio_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic        mem_w, cpu_mio;
  logic [31:0] rdata;
  logic        mio_ready;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we, ram_en;
  logic [31:0] ram_dout;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:16383];

  mio_bus_ctrl dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .mem_w(mem_w),
    .cpu_mio(cpu_mio), .rdata(rdata), .mio_ready(mio_ready), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_en(ram_en), .ram_dout(ram_dout),
    .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data valid one cycle after ram_en.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    addr = a; wdata = d; mem_w = w; cpu_mio = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; cpu_mio = 1'b1; addr = 32'h0000_0020; wdata = 32'h1111_2222; mem_w = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (mio_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", mio_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b expected 0", ram_we); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b expected 0", ram_en); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
    checks++; if (led_out !== 16'h0) begin errors++; $display("FAIL rst_led: got %h expected 0000", led_out); end
    // Release and issue a CNT read on the very first active edge.
    @(negedge clk);
    reset = 1'b1; addr = 32'hF000_0008; mem_w = 1'b0; cpu_mio = 1'b1;
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b1) begin errors++; $display("FAIL first_req_ready: got %b expected 1", mio_ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL first_cnt_read: got %h expected %h", rdata, 32'h0); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_ram_write;
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    #1;
    checks++; if (ram_addr !== 14'd4) begin errors++; $display("FAIL ramw_addr: got %h expected %h", ram_addr, 14'd4); end
    checks++; if (ram_we !== 1'b1 || ram_en !== 1'b1) begin errors++; $display("FAIL ramw_strobes: got we=%b en=%b expected 1 1", ram_we, ram_en); end
    checks++; if (ram_din !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ramw_din: got %h expected DEADBEEF", ram_din); end
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b1) begin errors++; $display("FAIL ramw_ready: got %b expected 1", mio_ready); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL ramw_single: got %b expected 0", ram_we); end
    checks++; if (mem[4] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ramw_mem: got %h expected DEADBEEF", mem[4]); end
    cpu_mio = 1'b0;
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL idle_quiet: got rdy=%b en=%b expected 0 0", mio_ready, ram_en); end
  endtask

  task automatic test_ram_read;
    // Request held through RD_WAIT and RESP must not start a second access.
    drive(32'h0000_0013, 32'h0, 1'b0);
    #1;
    checks++; if (ram_en !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL ramr_strobes: got en=%b we=%b expected 1 0", ram_en, ram_we); end
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL ramr_wait: got rdy=%b en=%b expected 0 0", mio_ready, ram_en); end
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b1) begin errors++; $display("FAIL ramr_ready: got %b expected 1", mio_ready); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ramr_data: got %h expected DEADBEEF", rdata); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_led;
    drive(32'hF000_0000, 32'h1234_5678, 1'b1);
    @(posedge clk); #1;
    checks++; if (led_out !== 16'h5678) begin errors++; $display("FAIL led_write: got %h expected 5678", led_out); end
    cpu_mio = 1'b0;
    @(posedge clk);
    drive(32'hF000_0002, 32'h0, 1'b0);
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0000_5678 || mio_ready !== 1'b1) begin errors++; $display("FAIL led_read: got %h rdy=%b expected 00005678 1", rdata, mio_ready); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_sw;
    drive(32'hF000_0004, 32'h0, 1'b0);
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0000_A5C3) begin errors++; $display("FAIL sw_read: got %h expected 0000A5C3", rdata); end
    cpu_mio = 1'b0;
    @(posedge clk);
    drive(32'hF000_0004, 32'hFFFF_0000, 1'b1);
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b1 || bus_err !== 1'b0) begin errors++; $display("FAIL sw_write_ack: got rdy=%b err=%b expected 1 0", mio_ready, bus_err); end
    checks++; if (led_out !== 16'h5678) begin errors++; $display("FAIL sw_write_side: got %h expected 5678", led_out); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_cnt_wrap;
    drive(32'hF000_0008, 32'hFFFF_FFFE, 1'b1);
    @(posedge clk); #1;
    cpu_mio = 1'b0;
    repeat (2) @(posedge clk);
    // Counter went FFFFFFFE -> FFFFFFFF -> 00000000 over those two edges.
    drive(32'hF000_0008, 32'h0, 1'b0);
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0000_0000) begin errors++; $display("FAIL cnt_wrap: got %h expected 00000000", rdata); end
  endtask

  task automatic test_back_to_back;
    // cpu_mio stays high from the previous CNT read: RESP ignores it, next IDLE accepts it.
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 0", mio_ready); end
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b1 || rdata !== 32'h0000_0002) begin errors++; $display("FAIL b2b_cnt: got %h rdy=%b expected 00000002 1", rdata, mio_ready); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_unmapped;
    drive(32'h8000_0000, 32'h0, 1'b0);
    #1;
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL unm_ram_en: got %b expected 0", ram_en); end
    @(posedge clk); #1;
    checks++; if (rdata !== 32'h0 || bus_err !== 1'b1 || mio_ready !== 1'b1) begin errors++; $display("FAIL unm_read: got %h err=%b rdy=%b expected 0 1 1", rdata, bus_err, mio_ready); end
    cpu_mio = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_err_pulse: got %b expected 0", bus_err); end
    drive(32'h0001_0000, 32'hCAFE_F00D, 1'b1);
    #1;
    checks++; if (ram_we !== 1'b0 || ram_en !== 1'b0) begin errors++; $display("FAIL unm_wr_ram: got we=%b en=%b expected 0 0", ram_we, ram_en); end
    @(posedge clk); #1;
    checks++; if (bus_err !== 1'b1 || mio_ready !== 1'b1) begin errors++; $display("FAIL unm_wr_ack: got err=%b rdy=%b expected 1 1", bus_err, mio_ready); end
    checks++; if (led_out !== 16'h5678) begin errors++; $display("FAIL unm_wr_side: got %h expected 5678", led_out); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    drive(32'h0000_0010, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0 || mio_ready !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rmid_out: got %h rdy=%b err=%b expected 0 0 0", rdata, mio_ready, bus_err); end
    checks++; if (ram_en !== 1'b0 || led_out !== 16'h0) begin errors++; $display("FAIL rmid_state: got en=%b led=%h expected 0 0000", ram_en, led_out); end
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b0) begin errors++; $display("FAIL rmid_no_ready: got %b expected 0", mio_ready); end
    cpu_mio = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (mio_ready !== 1'b0) begin errors++; $display("FAIL rmid_release: got %b expected 0", mio_ready); end
    drive(32'h0000_0010, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata !== 32'hDEAD_BEEF || mio_ready !== 1'b1) begin errors++; $display("FAIL rmid_resume: got %h rdy=%b expected DEADBEEF 1", rdata, mio_ready); end
    cpu_mio = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    sw_in = 16'hA5C3;
    ram_dout = 32'h0;
    test_reset();
    test_ram_write();
    test_ram_read();
    test_led();
    test_sw();
    test_cnt_wrap();
    test_back_to_back();
    test_unmapped();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
